// File: rtl/mem_access_unit.sv
// RV32 load/store memory access unit: IDLE/ACCESS/WAIT/DONE handshake with a busywait memory.
// Define MAU_TIMEOUT_EN to compile in the WAIT timeout abort (limit set by TIMEOUT_CYCLES).
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Mem_read,
  input  logic        Mem_write,
  input  logic [2:0]  Func3_in,
  input  logic [31:0] Address_in,
  input  logic [31:0] Store_data,
  output logic        Read,
  output logic        Write,
  output logic [31:0] Address,
  output logic [31:0] Write_data,
  output logic [2:0]  Func3,
  input  logic [31:0] Read_data,
  input  logic        busywait,
  output logic [31:0] Load_data,
  output logic        Stall,
  output logic        Fault
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] load_data_q, load_data_d;
  logic [2:0]  func3_q, func3_d;
  logic        is_write_q, is_write_d;
  logic        fault_q, fault_d;
  logic        strobe;
  logic        stall_c;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("mem_access_unit: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef MAU_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

  function automatic logic req_legal(input logic rd, input logic wr,
                                     input logic [2:0] f3, input logic [1:0] a);
    logic f3_ok;
    logic align_ok;
    if (rd) f3_ok = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else    f3_ok = f3 inside {3'b000, 3'b001, 3'b010};
    case (f3[1:0])
      2'b01:   align_ok = ~a[0];
      2'b10:   align_ok = (a == 2'b00);
      default: align_ok = 1'b1;
    endcase
    return (rd ^ wr) & f3_ok & align_ok;
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return {{24{d[7]}}, d[7:0]};
      3'b001:  return {{16{d[15]}}, d[15:0]};
      3'b100:  return {24'h0, d[7:0]};
      3'b101:  return {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    func3_d     = func3_q;
    is_write_d  = is_write_q;
    load_data_d = load_data_q;
    fault_d     = 1'b0;
    strobe      = 1'b0;
    stall_c     = 1'b0;
`ifdef MAU_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (Mem_read || Mem_write) begin
          if (req_legal(Mem_read, Mem_write, Func3_in, Address_in[1:0])) begin
            stall_c    = 1'b1;
            addr_d     = Address_in;
            wdata_d    = Store_data;
            func3_d    = Func3_in;
            is_write_d = Mem_write;
            state_d    = ACCESS;
          end else begin
            fault_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        strobe  = 1'b1;
        stall_c = 1'b1;
        state_d = WAIT;
`ifdef MAU_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      WAIT: begin
        if (busywait) begin
          strobe  = 1'b1;
          stall_c = 1'b1;
`ifdef MAU_TIMEOUT_EN
          if (wait_cnt_q == CNT_LAST) begin
            fault_d     = 1'b1;
            load_data_d = '0;
            state_d     = IDLE;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
`endif
        end else begin
          if (!is_write_q) load_data_d = extend_load(func3_q, Read_data);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: all architectural state is reset asynchronously; sequential blocks use only <=
  // so every flop samples the pre-edge value of every other flop.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      func3_q     <= '0;
      is_write_q  <= 1'b0;
      load_data_q <= '0;
      fault_q     <= 1'b0;
`ifdef MAU_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      func3_q     <= func3_d;
      is_write_q  <= is_write_d;
      load_data_q <= load_data_d;
      fault_q     <= fault_d;
`ifdef MAU_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  // IDLE stall follows the live request, so it is masked while Reset holds the FSM.
  assign Stall      = stall_c & ~Reset;
  assign Read       = strobe & ~is_write_q;
  assign Write      = strobe & is_write_q;
  assign Address    = addr_q;
  assign Write_data = wdata_q;
  assign Func3      = func3_q;
  assign Load_data  = load_data_q;
  assign Fault      = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed stimulus pushes expectations,
// a negedge monitor pops and compares on each completion or Fault pulse.
module tb_mem_access_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Mem_read = 1'b0;
  logic        Mem_write = 1'b0;
  logic [2:0]  Func3_in = 3'b000;
  logic [31:0] Address_in = 32'h0;
  logic [31:0] Store_data = 32'h0;
  logic [31:0] Read_data = 32'h0;
  logic        busywait = 1'b0;
  logic        Read, Write, Stall, Fault;
  logic [31:0] Address, Write_data, Load_data;
  logic [2:0]  Func3;

  always #5 Clock = ~Clock;

  mem_access_unit #(.TIMEOUT_CYCLES(8)) dut (
    .Clock(Clock), .Reset(Reset), .Mem_read(Mem_read), .Mem_write(Mem_write),
    .Func3_in(Func3_in), .Address_in(Address_in), .Store_data(Store_data),
    .Read(Read), .Write(Write), .Address(Address), .Write_data(Write_data),
    .Func3(Func3), .Read_data(Read_data), .busywait(busywait),
    .Load_data(Load_data), .Stall(Stall), .Fault(Fault)
  );

  typedef struct {
    bit          is_fault;
    bit          is_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] load;
    int          strobes;
    int          stalls;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  bit          active = 0, pending = 0, drift = 0;
  int          strobe_cnt = 0, stall_cnt = 0;
  logic        m_rd, m_wr;
  logic [31:0] m_addr, m_wdata;
  logic [2:0]  m_f3;
  exp_t        mon_e;

  always @(negedge Clock) begin
    if (Reset) begin
      active = 0; pending = 0; drift = 0; strobe_cnt = 0; stall_cnt = 0;
    end else begin
      if (Stall) stall_cnt++;
      if (Fault) begin
        if (exp_q.size() == 0) begin
          check("fault_without_expect", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_e = exp_q.pop_front();
          check("event_is_fault", 32'(mon_e.is_fault), 32'd1);
          check("fault_strobes", 32'(active ? strobe_cnt : 0), 32'(mon_e.strobes));
          check("fault_stalls", 32'(stall_cnt), 32'(mon_e.stalls));
          check("fault_load", Load_data, mon_e.load);
        end
        active = 0; pending = 0; strobe_cnt = 0; stall_cnt = 0;
      end else if (pending) begin
        if (exp_q.size() == 0) begin
          check("done_without_expect", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_e = exp_q.pop_front();
          check("event_is_fault", 32'(mon_e.is_fault), 32'd0);
          check("dir_write", 32'(m_wr), 32'(mon_e.is_write));
          check("dir_read", 32'(m_rd), 32'(!mon_e.is_write));
          check("address", m_addr, mon_e.addr);
          check("func3", 32'(m_f3), 32'(mon_e.f3));
          if (mon_e.is_write) check("write_data", m_wdata, mon_e.wdata);
          check("strobe_cycles", 32'(strobe_cnt), 32'(mon_e.strobes));
          check("stall_cycles", 32'(stall_cnt), 32'(mon_e.stalls));
          check("load_data", Load_data, mon_e.load);
          check("latched_stable", 32'(drift), 32'd0);
        end
        pending = 0; strobe_cnt = 0; stall_cnt = 0;
      end else if (Read || Write) begin
        if (!active) begin
          active = 1; drift = 0; strobe_cnt = 0;
          m_rd = Read; m_wr = Write; m_addr = Address; m_wdata = Write_data; m_f3 = Func3;
        end else if (Read !== m_rd || Write !== m_wr || Address !== m_addr ||
                     Write_data !== m_wdata || Func3 !== m_f3) begin
          drift = 1;
        end
        strobe_cnt++;
      end else if (active) begin
        active = 0;
        pending = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  // All tasks start and end 2 time units after a rising edge.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [31:0] rdata, input int nbusy,
                            input logic [31:0] exp_load);
    exp_t e;
    e.is_fault = 0; e.is_write = wr; e.addr = addr; e.wdata = sdata; e.f3 = f3;
    e.load = exp_load; e.strobes = nbusy + 1; e.stalls = nbusy + 2;
    exp_q.push_back(e);
    Mem_read = rd; Mem_write = wr; Func3_in = f3; Address_in = addr;
    Store_data = sdata; Read_data = ~rdata; busywait = 1'b0;
    @(posedge Clock); #2;                 // ACCESS: scramble request, busywait low
    Address_in = ~addr; Store_data = ~sdata; Func3_in = ~f3;
    for (int i = 0; i < nbusy; i++) begin
      @(posedge Clock); #2;
      busywait = 1'b1;
    end
    @(posedge Clock); #2;
    busywait = 1'b0; Read_data = rdata;
    @(posedge Clock); #2;                 // DONE
    Read_data = ~rdata;
    @(posedge Clock); #2;                 // IDLE
    Mem_read = 1'b0; Mem_write = 1'b0;
  endtask

  task automatic run_reject(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] cur_load);
    exp_t e;
    e.is_fault = 1; e.is_write = 0; e.addr = 0; e.wdata = 0; e.f3 = 0;
    e.load = cur_load; e.strobes = 0; e.stalls = 0;
    exp_q.push_back(e);
    Mem_read = rd; Mem_write = wr; Func3_in = f3; Address_in = addr;
    @(posedge Clock); #2;
    Mem_read = 1'b0; Mem_write = 1'b0;
    repeat (2) begin @(posedge Clock); #2; end
  endtask

  initial begin
    // Legal LW held during reset: Stall must stay low.
    Mem_read = 1'b1; Func3_in = 3'b010; Address_in = 32'h0;
    repeat (2) @(posedge Clock); #2;
    check("rst_read", 32'(Read), 32'd0);
    check("rst_write", 32'(Write), 32'd0);
    check("rst_stall", 32'(Stall), 32'd0);
    check("rst_fault", 32'(Fault), 32'd0);
    check("rst_address", Address, 32'h0);
    check("rst_write_data", Write_data, 32'h0);
    check("rst_func3", 32'(Func3), 32'd0);
    check("rst_load_data", Load_data, 32'h0);
    Mem_read = 1'b0; Reset = 1'b0;

    //          rd    wr    f3      addr   store         rdata         busy  load
    run_access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        3, 32'h00000000); // SW
    run_access(1'b1, 1'b0, 3'b000, 32'h05, 32'h0,        32'h000000AA, 0, 32'hFFFFFFAA); // LB
    run_access(1'b1, 1'b0, 3'b100, 32'h05, 32'h0,        32'h000000AA, 1, 32'h000000AA); // LBU
    run_access(1'b1, 1'b0, 3'b001, 32'h06, 32'h0,        32'h0000BBBB, 0, 32'hFFFFBBBB); // LH
    run_access(1'b1, 1'b0, 3'b101, 32'h02, 32'h0,        32'h00008001, 2, 32'h00008001); // LHU
    run_access(1'b1, 1'b0, 3'b001, 32'h00, 32'h0,        32'h00007FFF, 0, 32'h00007FFF); // LH +
    run_access(1'b1, 1'b0, 3'b000, 32'h03, 32'h0,        32'h1234567F, 0, 32'h0000007F); // LB +
    run_access(1'b1, 1'b0, 3'b010, 32'h0C, 32'h0,        32'hCAFEF00D, 2, 32'hCAFEF00D); // LW
    run_access(1'b0, 1'b1, 3'b000, 32'h03, 32'h00000055, 32'h0,        1, 32'hCAFEF00D); // SB
    run_access(1'b0, 1'b1, 3'b001, 32'h02, 32'h0000A5A5, 32'h0,        0, 32'hCAFEF00D); // SH

    run_reject(1'b1, 1'b0, 3'b001, 32'h07, 32'hCAFEF00D);   // LH misaligned
    run_reject(1'b1, 1'b0, 3'b010, 32'h06, 32'hCAFEF00D);   // LW misaligned
    run_reject(1'b1, 1'b1, 3'b010, 32'h08, 32'hCAFEF00D);   // read and write together
    run_reject(1'b1, 1'b0, 3'b011, 32'h00, 32'hCAFEF00D);   // illegal load funct3
    run_reject(1'b1, 1'b0, 3'b110, 32'h00, 32'hCAFEF00D);
    run_reject(1'b0, 1'b1, 3'b100, 32'h00, 32'hCAFEF00D);   // illegal store funct3
    run_reject(1'b0, 1'b1, 3'b010, 32'h02, 32'hCAFEF00D);   // SW misaligned
    run_reject(1'b0, 1'b1, 3'b001, 32'h01, 32'hCAFEF00D);   // SH misaligned

    // Reset in WAIT with busywait stuck high.
    Mem_read = 1'b1; Func3_in = 3'b010; Address_in = 32'h20; Store_data = 32'h77; busywait = 1'b0;
    @(posedge Clock); #2;
    Mem_read = 1'b0; busywait = 1'b1;
    repeat (3) @(posedge Clock);
    #3;
    check("pre_reset_read", 32'(Read), 32'd1);
    Reset = 1'b1;
    #1;
    check("midrst_read", 32'(Read), 32'd0);
    check("midrst_stall", 32'(Stall), 32'd0);
    check("midrst_address", Address, 32'h0);
    check("midrst_write_data", Write_data, 32'h0);
    check("midrst_load_data", Load_data, 32'h0);
    @(posedge Clock); #2;
    Reset = 1'b0;
    run_access(1'b1, 1'b0, 3'b010, 32'h04, 32'h0, 32'h12345678, 0, 32'h12345678);

`ifdef MAU_TIMEOUT_EN
    begin
      exp_t e;
      e.is_fault = 1; e.is_write = 0; e.addr = 0; e.wdata = 0; e.f3 = 0;
      e.load = 32'h0; e.strobes = 9; e.stalls = 10;
      exp_q.push_back(e);
    end
    Mem_read = 1'b1; Func3_in = 3'b010; Address_in = 32'h08; busywait = 1'b1;
    @(posedge Clock); #2;
    Mem_read = 1'b0;
    repeat (12) @(posedge Clock);
    #2;
    check("timeout_read_low", 32'(Read), 32'd0);
    check("timeout_stall_low", 32'(Stall), 32'd0);
    busywait = 1'b0;
`else
    Mem_read = 1'b1; Func3_in = 3'b010; Address_in = 32'h08; busywait = 1'b1;
    @(posedge Clock); #2;
    Mem_read = 1'b0;
    repeat (110) @(posedge Clock);
    #2;
    check("hang_stall_held", 32'(Stall), 32'd1);
    check("hang_read_held", 32'(Read), 32'd1);
    check("hang_no_fault", 32'(Fault), 32'd0);
    Reset = 1'b1;
    #1;
    check("hang_rst_stall", 32'(Stall), 32'd0);
    @(posedge Clock); #2;
    Reset = 1'b0; busywait = 1'b0;
`endif

    repeat (4) @(posedge Clock);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("monitor_idle", 32'({active, pending}), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
